// File: rtl/frame2xgmii_tx.sv
// Encodes a 64-bit byte-stream frame interface into XGMII TX words: start word,
// data, terminate, minimum inter-frame gap and underrun error signalling.
module frame2xgmii_tx #(
    parameter int IFG_WORDS = 2
) (
    input  logic        xgmii_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] s_tdata,
    input  logic [7:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  xgmii_txc,
    output logic [63:0] xgmii_txd,
    output logic [31:0] tx_frames,
    output logic [15:0] tx_underruns,
    output logic        busy
);
    localparam logic [63:0] IDLE_TXD  = 64'h0707070707070707;
    localparam logic [63:0] START_TXD = 64'hd5555555555555fb;
    localparam logic [63:0] ERROR_TXD = 64'hfefefefefefefefe;
    localparam logic [63:0] TERM_TXD  = 64'h07070707070707fd;
    localparam int CW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, DATA, TERM, IFG, DRAIN} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] ifg_cnt;
    logic [CW-1:0] next_ifg_cnt;
    logic [7:0]    next_txc;
    logic [63:0]   next_txd;
    logic          inc_frames;
    logic          inc_underruns;
    logic [3:0]    keep_len;
    logic [7:0]    term_txc;
    logic [63:0]   term_txd;

    assign s_tready = (state == DATA) || (state == DRAIN);
    assign busy     = (state != IDLE);

    // Length of the leading run of ones in tkeep; bits above the first zero are ignored.
    always_comb begin
        keep_len = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (s_tkeep[i] && (keep_len == 4'(i))) begin
                keep_len = 4'(i + 1);
            end
        end
    end

    always_comb begin
        term_txc = 8'h00;
        term_txd = IDLE_TXD;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < keep_len) begin
                term_txd[8*i +: 8] = s_tdata[8*i +: 8];
            end else begin
                term_txc[i] = 1'b1;
                if (4'(i) == keep_len) begin
                    term_txd[8*i +: 8] = 8'hfd;
                end
            end
        end
    end

    always_comb begin
        next_state    = state;
        next_ifg_cnt  = ifg_cnt;
        next_txc      = 8'hff;
        next_txd      = IDLE_TXD;
        inc_frames    = 1'b0;
        inc_underruns = 1'b0;
        unique case (state)
            IDLE: begin
                if (s_tvalid) begin
                    next_txc   = 8'h01;
                    next_txd   = START_TXD;
                    next_state = DATA;
                end
            end
            DATA: begin
                if (!s_tvalid) begin
                    next_txd      = ERROR_TXD;
                    inc_underruns = 1'b1;
                    next_state    = DRAIN;
                end else if (s_tlast && (keep_len != 4'd8)) begin
                    next_txc     = term_txc;
                    next_txd     = term_txd;
                    inc_frames   = 1'b1;
                    next_ifg_cnt = '0;
                    next_state   = IFG;
                end else begin
                    next_txc = 8'h00;
                    next_txd = s_tdata;
                    if (s_tlast) begin
                        next_state = TERM;
                    end
                end
            end
            TERM: begin
                next_txd     = TERM_TXD;
                inc_frames   = 1'b1;
                next_ifg_cnt = '0;
                next_state   = IFG;
            end
            IFG: begin
                if (ifg_cnt == CW'(IFG_WORDS - 1)) begin
                    next_state = IDLE;
                end else begin
                    next_ifg_cnt = ifg_cnt + CW'(1);
                end
            end
            DRAIN: begin
                // Beats are accepted and discarded until the end of the broken frame.
                if (s_tvalid && s_tlast) begin
                    next_ifg_cnt = '0;
                    next_state   = IFG;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge xgmii_clk) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            ifg_cnt      <= '0;
            xgmii_txc    <= 8'hff;
            xgmii_txd    <= IDLE_TXD;
            tx_frames    <= '0;
            tx_underruns <= '0;
        end else begin
            state     <= next_state;
            ifg_cnt   <= next_ifg_cnt;
            xgmii_txc <= next_txc;
            xgmii_txd <= next_txd;
            if (inc_frames) begin
                tx_frames <= tx_frames + 32'd1;
            end
            if (inc_underruns) begin
                tx_underruns <= tx_underruns + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_frame2xgmii_tx.sv
// Bench for frame2xgmii_tx: random frames are checked at frame level by a
// monitor that re-assembles the XGMII stream and compares it against per-frame records.
module tb_frame2xgmii_tx;
    localparam int IFG_WORDS = 2;
    localparam logic [63:0] IDLE_TXD  = 64'h0707070707070707;
    localparam logic [63:0] START_TXD = 64'hd5555555555555fb;
    localparam logic [63:0] ERROR_TXD = 64'hfefefefefefefefe;
    localparam logic [31:0] HASH_INIT = 32'h811c9dc5;

    logic        xgmii_clk;
    logic        sys_rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  xgmii_txc;
    logic [63:0] xgmii_txd;
    logic [31:0] tx_frames;
    logic [15:0] tx_underruns;
    logic        busy;

    typedef struct {
        int          len;
        logic [31:0] hash;
        bit          err;
        bit          gap_exact;
    } frame_rec_t;

    frame_rec_t  exp_q[$];
    frame_rec_t  cur;
    int          assert_count = 0;
    int          fail_count = 0;
    bit          mon_on = 0;
    logic        rst_prev;
    logic        acc_prev;
    logic [63:0] data_prev;
    bit          in_frame = 0;
    int          gap_count = IFG_WORDS;
    int          obs_len;
    logic [31:0] obs_hash;
    int          exp_frames = 0;
    int          exp_under = 0;

    frame2xgmii_tx #(.IFG_WORDS(IFG_WORDS)) dut (
        .xgmii_clk    (xgmii_clk),
        .sys_rst_n    (sys_rst_n),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tlast      (s_tlast),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .xgmii_txc    (xgmii_txc),
        .xgmii_txd    (xgmii_txd),
        .tx_frames    (tx_frames),
        .tx_underruns (tx_underruns),
        .busy         (busy)
    );

    initial xgmii_clk = 1'b0;
    always #5 xgmii_clk = ~xgmii_clk;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hash_byte(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'h0, b}) * 32'h01000193;
    endfunction

    // Last-beat keep with exactly n leading ones; bits above the first zero are random.
    function automatic logic [7:0] keep_for(input int n);
        logic [7:0] k;
        k = 8'($urandom);
        if (n >= 8) return 8'hff;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        k[n] = 1'b0;
        return k;
    endfunction

    task automatic wait_accept();
        for (int c = 0; c < 50; c++) begin
            @(negedge xgmii_clk);
            if (s_tready) begin
                @(posedge xgmii_clk);
                #1;
                return;
            end
        end
        check_output("acceptTimeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) begin
            @(posedge xgmii_clk);
            #1;
        end
    endtask

    // Sends one frame; drop_after > 0 withholds s_tvalid for one cycle after that many beats.
    task automatic apply_stimulus(input int nbeats, input int n, input int drop_after, input bit gap_exact);
        logic [63:0] beat[16];
        frame_rec_t  rec;
        int          nbytes;
        rec.len       = 0;
        rec.hash      = HASH_INIT;
        rec.err       = (drop_after > 0);
        rec.gap_exact = gap_exact;
        for (int b = 0; b < nbeats; b++) begin
            beat[b] = {$urandom, $urandom};
            if (rec.err) nbytes = (b < drop_after) ? 8 : 0;
            else         nbytes = (b < nbeats - 1) ? 8 : n;
            for (int i = 0; i < nbytes; i++) begin
                rec.hash = hash_byte(rec.hash, beat[b][8*i +: 8]);
                rec.len++;
            end
        end
        exp_q.push_back(rec);
        for (int b = 0; b < nbeats; b++) begin
            if (drop_after > 0 && b == drop_after) begin
                s_tvalid = 1'b0;
                @(posedge xgmii_clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = beat[b];
            s_tlast  = (b == nbeats - 1);
            s_tkeep  = (b == nbeats - 1) ? keep_for(n) : 8'($urandom);
            wait_accept();
        end
    endtask

    always @(posedge xgmii_clk) begin
        rst_prev  <= !sys_rst_n;
        acc_prev  <= s_tvalid && s_tready;
        data_prev <= s_tdata;
    end

    // Re-assembles frames from the wire and compares them with the queued records.
    always @(negedge xgmii_clk) begin : monitor
        int          k;
        bit          err;
        logic [7:0]  exp_txc;
        logic [63:0] exp_txd;
        if (mon_on) begin
            if (rst_prev) begin
                check_output("rstTxc", xgmii_txc, 8'hff);
                check_output("rstTxd", xgmii_txd, IDLE_TXD);
                check_output("rstReady", s_tready, 0);
                check_output("rstBusy", busy, 0);
                check_output("rstFrames", tx_frames, 0);
                check_output("rstUnderruns", tx_underruns, 0);
                in_frame   = 0;
                exp_frames = 0;
                exp_under  = 0;
                gap_count  = IFG_WORDS;
            end else if (!in_frame) begin
                if (xgmii_txc == 8'h01) begin
                    check_output("startWord", xgmii_txd, START_TXD);
                    check_output("startNoAccept", acc_prev, 0);
                    if (exp_q.size() == 0) begin
                        check_output("unexpectedStart", 1, 0);
                        cur = '{len: -1, hash: 32'h0, err: 1'b0, gap_exact: 1'b0};
                    end else begin
                        cur = exp_q.pop_front();
                        if (cur.gap_exact) check_output("ifgExact", gap_count, IFG_WORDS);
                        else               check_output("ifgMin", gap_count >= IFG_WORDS, 1);
                    end
                    in_frame = 1;
                    obs_len  = 0;
                    obs_hash = HASH_INIT;
                end else begin
                    check_output("idleWord", {xgmii_txc, xgmii_txd}, {8'hff, IDLE_TXD});
                    gap_count++;
                end
            end else if (xgmii_txc == 8'h00) begin
                check_output("dataAccepted", acc_prev, 1);
                check_output("dataLatency", xgmii_txd, data_prev);
                for (int i = 0; i < 8; i++) begin
                    obs_hash = hash_byte(obs_hash, xgmii_txd[8*i +: 8]);
                    obs_len++;
                end
            end else begin
                k = 0;
                for (int i = 7; i >= 0; i--) if (xgmii_txc[i]) k = i;
                if (xgmii_txd[8*k +: 8] == 8'hfe) begin
                    check_output("errWord", {xgmii_txc, xgmii_txd}, {8'hff, ERROR_TXD});
                    err = 1;
                    exp_under++;
                end else begin
                    exp_txc = 8'hff << k;
                    exp_txd = IDLE_TXD;
                    for (int i = 0; i < 8; i++) begin
                        if (i < k)       exp_txd[8*i +: 8] = data_prev[8*i +: 8];
                        else if (i == k) exp_txd[8*i +: 8] = 8'hfd;
                    end
                    if (k > 0) check_output("termAccepted", acc_prev, 1);
                    check_output("termWord", {xgmii_txc, xgmii_txd}, {exp_txc, exp_txd});
                    for (int i = 0; i < k; i++) begin
                        obs_hash = hash_byte(obs_hash, xgmii_txd[8*i +: 8]);
                        obs_len++;
                    end
                    err = 0;
                    exp_frames++;
                end
                check_output("frameErr", err, cur.err);
                check_output("frameLen", obs_len, cur.len);
                check_output("frameHash", obs_hash, cur.hash);
                check_output("txFrames", tx_frames, 32'(exp_frames));
                check_output("txUnderruns", tx_underruns, 16'(exp_under));
                in_frame  = 0;
                gap_count = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  idle;
        int  nbeats;
        int  n;
        int  drop;
        bit  prev_clean;
        sys_rst_n = 1'b0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        s_tkeep   = 8'h00;
        s_tdata   = 64'h0;
        @(posedge xgmii_clk);
        #1;
        mon_on = 1;
        repeat (2) begin
            @(posedge xgmii_clk);
            #1;
        end
        sys_rst_n = 1'b1;

        idle_cycles(5);
        @(negedge xgmii_clk);
        check_output("idleReady", s_tready, 0);
        check_output("idleBusy", busy, 0);
        #1;

        apply_stimulus(3, 3, 0, 0);
        idle_cycles(6);
        apply_stimulus(2, 8, 0, 0);
        idle_cycles(6);
        apply_stimulus(4, 8, 1, 0);
        idle_cycles(6);
        apply_stimulus(2, 5, 0, 0);
        idle_cycles(6);

        apply_stimulus(2, 8, 0, 0);
        apply_stimulus(3, 5, 0, 1);
        apply_stimulus(1, 0, 0, 1);
        apply_stimulus(2, 7, 0, 1);
        idle_cycles(6);

        exp_q.push_back('{len: 0, hash: HASH_INIT, err: 1'b0, gap_exact: 1'b0});
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = {$urandom, $urandom};
        wait_accept();
        s_tdata = {$urandom, $urandom};
        wait_accept();
        sys_rst_n = 1'b0;
        s_tvalid  = 1'b0;
        repeat (2) begin
            @(posedge xgmii_clk);
            #1;
        end
        sys_rst_n = 1'b1;
        apply_stimulus(3, 2, 0, 0);
        idle_cycles(6);

        prev_clean = 0;
        for (int f = 0; f < 40; f++) begin
            idle = $urandom_range(0, 3);
            if (idle > 0) idle_cycles(idle);
            nbeats = $urandom_range(1, 6);
            n      = $urandom_range(0, 8);
            drop   = 0;
            if (nbeats > 1 && $urandom_range(0, 9) == 0) drop = $urandom_range(1, nbeats - 1);
            apply_stimulus(nbeats, n, drop, (idle == 0) && prev_clean);
            prev_clean = (drop == 0);
        end
        idle_cycles(10);

        @(negedge xgmii_clk);
        check_output("pendingFrames", exp_q.size(), 0);
        check_output("endInFrame", in_frame, 0);
        check_output("endBusy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
